// File: rtl/regfile_arb_pkg.sv
// Shared widths, FSM state encoding and grant encoding for the register-file
// write arbiter.
package regfile_arb_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request/ack signals of the ALU and MEM paths plus the single
// register-file write port, as seen by the arbiter (master) and its environment (slave).
interface regfile_write_arbiter_if;
  import regfile_arb_pkg::*;

  logic              aluReq;
  logic [REG_W-1:0]  aluReg;
  logic [DATA_W-1:0] aluVal;
  logic              aluAck;
  logic              memReq;
  logic [REG_W-1:0]  memReg;
  logic [DATA_W-1:0] memVal;
  logic              memAck;
  logic [REG_W-1:0]  destReg;
  logic [DATA_W-1:0] destVal;
  logic              storeNow;
  logic              storeDone;
  logic              busy;
  logic              err;

  modport master (
    input  aluReq, aluReg, aluVal, memReq, memReg, memVal, storeDone,
    output aluAck, memAck, destReg, destVal, storeNow, busy, err
  );

  modport slave (
    output aluReq, aluReg, aluVal, memReq, memReg, memVal, storeDone,
    input  aluAck, memAck, destReg, destVal, storeNow, busy, err
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Combinational two-way winner select between the ALU and MEM writeback sources,
// either round-robin on lastGrant or fixed with the ALU on top.
module rr_arbiter2
  import regfile_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic   aluReq_i,
  input  logic   memReq_i,
  input  grant_e lastGrant_i,
  output logic   valid_o,
  output grant_e winner_o
);

  always_comb begin
    valid_o  = aluReq_i | memReq_i;
    winner_o = GNT_ALU;
    if (aluReq_i && memReq_i) begin
      // In round-robin mode a tie goes to whoever was not served last.
      if (PRIORITY_MODE == 0 && lastGrant_i == GNT_ALU) begin
        winner_o = GNT_MEM;
      end
    end else if (memReq_i) begin
      winner_o = GNT_MEM;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and MEM writeback paths:
// IDLE/STORE/RELEASE handshake FSM, destination latch and store timeout.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int STORE_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.master bus
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(STORE_TIMEOUT);
  localparam bit         TIMEOUT_EN  = (STORE_TIMEOUT != 0);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            lastGrant_q, lastGrant_d;
  logic [REG_W-1:0]  destReg_q, destReg_d;
  logic [DATA_W-1:0] destVal_q, destVal_d;
  logic              aluAck_q, aluAck_d;
  logic              memAck_q, memAck_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;

  logic   reqValid;
  grant_e winner;

  rr_arbiter2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .aluReq_i    (bus.aluReq),
    .memReq_i    (bus.memReq),
    .lastGrant_i (lastGrant_q),
    .valid_o     (reqValid),
    .winner_o    (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GNT_ALU;
      lastGrant_q <= GNT_MEM;
      destReg_q   <= '0;
      destVal_q   <= '0;
      aluAck_q    <= 1'b0;
      memAck_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      destReg_q   <= destReg_d;
      destVal_q   <= destVal_d;
      aluAck_q    <= aluAck_d;
      memAck_q    <= memAck_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    destReg_d   = destReg_q;
    destVal_d   = destVal_q;
    aluAck_d    = 1'b0;
    memAck_d    = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          destReg_d   = (winner == GNT_ALU) ? bus.aluReg : bus.memReg;
          destVal_d   = (winner == GNT_ALU) ? bus.aluVal : bus.memVal;
          grant_d     = winner;
          lastGrant_d = winner;
          cnt_d       = '0;
          state_d     = STORE;
        end
      end
      STORE: begin
        // A timed-out write is acknowledged as if it completed; err records the loss.
        if (bus.storeDone || (TIMEOUT_EN && cnt_q == TIMEOUT_CNT)) begin
          state_d  = RELEASE;
          aluAck_d = (grant_q == GNT_ALU);
          memAck_d = (grant_q == GNT_MEM);
          if (!bus.storeDone) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RELEASE: begin
        if (!bus.storeDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.storeNow = (state_q == STORE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.destReg  = destReg_q;
  assign bus.destVal  = destVal_q;
  assign bus.aluAck   = aluAck_q;
  assign bus.memAck   = memAck_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter, each in front of
// a small behavioural register file that answers storeNow one cycle later.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        aluReq = 1'b0;
  logic        memReq = 1'b0;
  logic [3:0]  aluReg = '0;
  logic [3:0]  memReg = '0;
  logic [15:0] aluVal = '0;
  logic [15:0] memVal = '0;
  logic        stuck  = 1'b0;
  logic        useFx  = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [3:0]  aRegs[4];
  logic [15:0] aVals[4];
  logic [3:0]  mRegs[4];
  logic [15:0] mVals[4];
  logic [4:0]  order[$];

  regfile_write_arbiter_if ifRr ();
  regfile_write_arbiter_if ifFx ();

  assign ifRr.aluReq = aluReq;
  assign ifRr.aluReg = aluReg;
  assign ifRr.aluVal = aluVal;
  assign ifRr.memReq = memReq;
  assign ifRr.memReg = memReg;
  assign ifRr.memVal = memVal;
  assign ifFx.aluReq = aluReq;
  assign ifFx.aluReg = aluReg;
  assign ifFx.aluVal = aluVal;
  assign ifFx.memReq = memReq;
  assign ifFx.memReg = memReg;
  assign ifFx.memVal = memVal;

  regfile_write_arbiter #(.PRIORITY_MODE(0), .STORE_TIMEOUT(15)) dutRr (
    .clk (clk),
    .rst (rst),
    .bus (ifRr.master)
  );

  regfile_write_arbiter #(.PRIORITY_MODE(1), .STORE_TIMEOUT(15)) dutFx (
    .clk (clk),
    .rst (rst),
    .bus (ifFx.master)
  );

  logic [15:0] rfRr[16];
  logic [15:0] rfFx[16];

  // Register file stand-in: writes on storeNow, raises storeDone one cycle later.
  always @(posedge clk) begin
    if (ifRr.storeNow && !stuck) rfRr[ifRr.destReg] <= ifRr.destVal;
    ifRr.storeDone <= ifRr.storeNow && !stuck;
    if (ifFx.storeNow && !stuck) rfFx[ifFx.destReg] <= ifFx.destVal;
    ifFx.storeDone <= ifFx.storeNow && !stuck;
  end

  logic selAluAck, selMemAck;
  assign selAluAck = useFx ? ifFx.aluAck : ifRr.aluAck;
  assign selMemAck = useFx ? ifFx.memAck : ifRr.memAck;

  task automatic doReset();
    @(negedge clk);
    rst    = 1'b1;
    aluReq = 1'b0;
    memReq = 1'b0;
    stuck  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Serves aN ALU and mN MEM writes from the tables, re-requesting in each ack cycle.
  task automatic runWrites(input int aN, input int mN);
    int ai  = 0;
    int mi  = 0;
    int cyc = 0;
    order.delete();
    if (aN > 0) begin aluReq = 1'b1; aluReg = aRegs[0]; aluVal = aVals[0]; end
    if (mN > 0) begin memReq = 1'b1; memReg = mRegs[0]; memVal = mVals[0]; end
    while ((ai < aN || mi < mN) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (selAluAck) begin
        order.push_back({1'b0, aluReg});
        ai++;
        if (ai < aN) begin aluReg = aRegs[ai]; aluVal = aVals[ai]; end
        else aluReq = 1'b0;
      end
      if (selMemAck) begin
        order.push_back({1'b1, memReg});
        mi++;
        if (mi < mN) begin memReg = mRegs[mi]; memVal = mVals[mi]; end
        else memReq = 1'b0;
      end
    end
    tests++;
    if (ai < aN || mi < mN) begin
      fails++;
      $display("[TB] FAIL write_sequence: %0d acks seen, %0d required", ai + mi, aN + mN);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    tests++; if (ifRr.storeNow !== 1'b0) begin fails++; $display("[TB] FAIL reset_storeNow: got %b want 0", ifRr.storeNow); end
    tests++; if (ifRr.destReg !== 4'd0) begin fails++; $display("[TB] FAIL reset_destReg: got %h want 0", ifRr.destReg); end
    tests++; if (ifRr.destVal !== 16'd0) begin fails++; $display("[TB] FAIL reset_destVal: got %h want 0", ifRr.destVal); end
    tests++; if (ifRr.aluAck !== 1'b0) begin fails++; $display("[TB] FAIL reset_aluAck: got %b want 0", ifRr.aluAck); end
    tests++; if (ifRr.memAck !== 1'b0) begin fails++; $display("[TB] FAIL reset_memAck: got %b want 0", ifRr.memAck); end
    tests++; if (ifRr.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", ifRr.busy); end
    tests++; if (ifRr.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b want 0", ifRr.err); end
  endtask

  task automatic test_single_alu();
    int firstNow = -1;
    int ackAt    = -1;
    int ackCount = 0;
    logic [3:0]  nowReg = '0;
    logic [15:0] nowVal = '0;
    doReset();
    aluReg = 4'd3;
    aluVal = 16'h0100;
    aluReq = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ifRr.storeNow && firstNow < 0) begin
        firstNow = k;
        nowReg   = ifRr.destReg;
        nowVal   = ifRr.destVal;
      end
      if (ifRr.aluAck) begin
        ackCount++;
        if (ackAt < 0) ackAt = k;
        aluReq = 1'b0;
      end
    end
    tests++; if (firstNow != 1) begin fails++; $display("[TB] FAIL single_storeNow_cycle: got %0d want 1", firstNow); end
    tests++; if (nowReg !== 4'd3 || nowVal !== 16'h0100) begin fails++; $display("[TB] FAIL single_dest: got r%0d=%h want r3=0100", nowReg, nowVal); end
    tests++; if (ackAt != 3) begin fails++; $display("[TB] FAIL single_latency: got %0d want 3", ackAt); end
    tests++; if (ackCount != 1) begin fails++; $display("[TB] FAIL single_ack_pulses: got %0d want 1", ackCount); end
    tests++; if (rfRr[3] !== 16'h0100) begin fails++; $display("[TB] FAIL single_r3: got %h want 0100", rfRr[3]); end
    tests++; if (ifRr.busy !== 1'b0) begin fails++; $display("[TB] FAIL single_busy_after: got %b want 0", ifRr.busy); end
  endtask

  task automatic test_round_robin();
    doReset();
    aRegs[0] = 4'd1; aVals[0] = 16'h1111;
    aRegs[1] = 4'd4; aVals[1] = 16'h4444;
    mRegs[0] = 4'd2; mVals[0] = 16'h2222;
    mRegs[1] = 4'd5; mVals[1] = 16'h5555;
    runWrites(2, 2);
    tests++; if (order.size() != 4) begin fails++; $display("[TB] FAIL rr_count: got %0d want 4", order.size()); end
    tests++; if (order[0] !== 5'h01) begin fails++; $display("[TB] FAIL rr_order0: got %h want 01", order[0]); end
    tests++; if (order[1] !== 5'h12) begin fails++; $display("[TB] FAIL rr_order1: got %h want 12", order[1]); end
    tests++; if (order[2] !== 5'h04) begin fails++; $display("[TB] FAIL rr_order2: got %h want 04", order[2]); end
    tests++; if (order[3] !== 5'h15) begin fails++; $display("[TB] FAIL rr_order3: got %h want 15", order[3]); end
    tests++; if (rfRr[1] !== 16'h1111 || rfRr[2] !== 16'h2222 || rfRr[4] !== 16'h4444 || rfRr[5] !== 16'h5555) begin
      fails++;
      $display("[TB] FAIL rr_data: got %h %h %h %h want 1111 2222 4444 5555", rfRr[1], rfRr[2], rfRr[4], rfRr[5]);
    end
  endtask

  task automatic test_same_reg();
    doReset();
    aRegs[0] = 4'd7; aVals[0] = 16'hAAAA;
    mRegs[0] = 4'd7; mVals[0] = 16'hBBBB;
    runWrites(1, 1);
    tests++; if (order.size() != 2 || order[0] !== 5'h07 || order[1] !== 5'h17) begin
      fails++;
      $display("[TB] FAIL same_reg_order: got %0d entries %h %h want 07 17", order.size(), order[0], order[1]);
    end
    tests++; if (rfRr[7] !== 16'hBBBB) begin fails++; $display("[TB] FAIL same_reg_r7: got %h want BBBB", rfRr[7]); end
  endtask

  task automatic test_fixed_priority();
    useFx = 1'b1;
    doReset();
    aRegs[0] = 4'd8;  aVals[0] = 16'h0808;
    aRegs[1] = 4'd9;  aVals[1] = 16'h0909;
    aRegs[2] = 4'd10; aVals[2] = 16'h0A0A;
    mRegs[0] = 4'd11; mVals[0] = 16'h0B0B;
    runWrites(3, 1);
    tests++; if (order.size() != 4) begin fails++; $display("[TB] FAIL fixed_count: got %0d want 4", order.size()); end
    tests++; if (order[0] !== 5'h08) begin fails++; $display("[TB] FAIL fixed_order0: got %h want 08", order[0]); end
    tests++; if (order[1] !== 5'h09) begin fails++; $display("[TB] FAIL fixed_order1: got %h want 09", order[1]); end
    tests++; if (order[2] !== 5'h0A) begin fails++; $display("[TB] FAIL fixed_order2: got %h want 0a", order[2]); end
    tests++; if (order[3] !== 5'h1B) begin fails++; $display("[TB] FAIL fixed_order3: got %h want 1b", order[3]); end
    tests++; if (rfFx[11] !== 16'h0B0B) begin fails++; $display("[TB] FAIL fixed_r11: got %h want 0b0b", rfFx[11]); end
    useFx = 1'b0;
  endtask

  task automatic test_timeout();
    int   firstNow  = -1;
    int   ackAt     = -1;
    logic errBefore = 1'bx;
    logic errAtAck  = 1'bx;
    doReset();
    stuck  = 1'b1;
    aluReg = 4'd6;
    aluVal = 16'h0666;
    aluReq = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ifRr.storeNow && firstNow < 0) firstNow = k;
      if (k == 16) errBefore = ifRr.err;
      if (ifRr.aluAck && ackAt < 0) begin
        ackAt    = k;
        errAtAck = ifRr.err;
        aluReq   = 1'b0;
      end
    end
    tests++; if (firstNow != 1) begin fails++; $display("[TB] FAIL timeout_storeNow_cycle: got %0d want 1", firstNow); end
    tests++; if (ackAt - firstNow != 16) begin fails++; $display("[TB] FAIL timeout_ack_delay: got %0d want 16", ackAt - firstNow); end
    tests++; if (errBefore !== 1'b0) begin fails++; $display("[TB] FAIL timeout_err_early: got %b want 0", errBefore); end
    tests++; if (errAtAck !== 1'b1) begin fails++; $display("[TB] FAIL timeout_err_at_ack: got %b want 1", errAtAck); end
    tests++; if (ifRr.err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_err_sticky: got %b want 1", ifRr.err); end
    tests++; if (ifRr.busy !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy_after: got %b want 0", ifRr.busy); end
    doReset();
    tests++; if (ifRr.err !== 1'b0) begin fails++; $display("[TB] FAIL timeout_err_cleared: got %b want 0", ifRr.err); end
  endtask

  task automatic test_reset_mid_store();
    doReset();
    aluReg = 4'd12;
    aluVal = 16'hCCCC;
    aluReq = 1'b1;
    @(negedge clk);
    tests++; if (ifRr.storeNow !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_store: got %b want 1", ifRr.storeNow); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (ifRr.storeNow !== 1'b0) begin fails++; $display("[TB] FAIL midrst_storeNow: got %b want 0", ifRr.storeNow); end
    tests++; if (ifRr.busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b want 0", ifRr.busy); end
    tests++; if (ifRr.aluAck !== 1'b0) begin fails++; $display("[TB] FAIL midrst_ack: got %b want 0", ifRr.aluAck); end
    @(negedge clk);
    tests++; if (ifRr.aluAck !== 1'b0) begin fails++; $display("[TB] FAIL midrst_ack_late: got %b want 0", ifRr.aluAck); end
    rst = 1'b0;
    aRegs[0] = 4'd13; aVals[0] = 16'hD0D0;
    mRegs[0] = 4'd14; mVals[0] = 16'hE0E0;
    runWrites(1, 1);
    tests++; if (order.size() != 2 || order[0] !== 5'h0D) begin
      fails++;
      $display("[TB] FAIL midrst_first_tie: got %0d entries first %h want 0d", order.size(), order[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_round_robin();
    test_same_reg();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
